mac_unit_vert_seq: RTL and testbench
====================================

Name: mac_unit_vert_seq

Overview:
- Parametrised, self-sequencing successor of the 16-lane vertical bit-column MAC.
- Latches one activation vector, computes the per-group activation sums internally, then accepts one weight bit-column per handshake and accumulates the shifted column partial sums.
- Emits one signed dot-product result per operation behind a valid/ready output.
- Generalised in lane count, group count, weight precision (1..WEIGHT_BITS columns at runtime) and signed/unsigned weights.

Parameters:
- DATA_WIDTH, 8: activation width (signed).
- VEC_LENGTH, 16: activations per vector.
- GROUP_SIZE, 8: activations per group. VEC_LENGTH must be a multiple of it; NUM_GROUPS = VEC_LENGTH/GROUP_SIZE.
- SLOTS, GROUP_SIZE/2: selected activations per group per column.
- WEIGHT_BITS, 8: maximum columns per operation.
- SEL_W, $clog2(GROUP_SIZE+1): slot select width. Value GROUP_SIZE selects zero.
- ACC_W, DATA_WIDTH+$clog2(VEC_LENGTH)+WEIGHT_BITS+2: accumulator and result width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  activation vector offered.
- in_ready  out  1  unit can accept a vector.
- act  in  DATA_WIDTH x VEC_LENGTH  signed activations.
- signed_w  in  1  weights two's-complement (last column negated); latched with act.
- col_valid  in  1  weight column offered.
- col_ready  out  1  unit can accept a column.
- col_sel  in  SEL_W x (NUM_GROUPS*SLOTS)  in-group index per slot.
- col_skip_zero  in  NUM_GROUPS  1 = add selected activations; 0 = add group sum minus selected.
- col_last  in  1  column is the MSB column.
- ham_en  in  1  enable hamming correction term.
- ham_sel  in  $clog2(VEC_LENGTH)  global activation index for the correction.
- ham_sign  in  1  negate correction term.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  ACC_W  signed accumulated dot product.
- col_overrun  out  1  sticky: operation hit WEIGHT_BITS columns without col_last.

Behaviour:
- Reset (reset=0, async): state IDLE; in_ready=1; col_ready=0; out_valid=0; result=0; col_overrun=0; column index=0; pipeline registers=0.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid, register act and signed_w, clear the accumulator, clear col_overrun, go to LOAD.
- LOAD (1 cycle): register group sums S_g, each DATA_WIDTH+$clog2(GROUP_SIZE) bits. Go to RUN.
- RUN: col_ready=1. Each accepted column is registered into stage 1:
  - slot muxes; a select value >= GROUP_SIZE yields 0.
  - column index k.
  - MSB flag = col_last AND signed_w.
  - ham term = ham_en ? act[ham_sel] : 0.
  - k increments on each accepted column.
- Last-column rule: a column is last if col_last=1 or k=WEIGHT_BITS-1. The forced case (k=WEIGHT_BITS-1 with col_last=0) sets col_overrun. After the last column, go to DRAIN.
- Stage 2, per column:
  - P_g = sum of the group's slots.
  - C_g = skip_zero ? P_g : S_g - P_g.
  - T = sum over g of C_g, sign-extended; negate T if the MSB flag is set.
  - Term = (T <<< k) + ((ham_sign ? -H : H) <<< k), where H is the ham term. The ham term is never MSB-negated.
  - acc += Term.
- Column latency: a column accepted at cycle t is reflected in acc at cycle t+2. Back-to-back columns are accepted one per cycle.
- DRAIN: 2 cycles, then DONE.
- DONE: out_valid=1; result holds acc and stays stable until out_ready=1. On the out_valid & out_ready cycle, go to IDLE. in_ready is 0 until IDLE (no overlap).
- Idle-state inputs: col_valid outside RUN is ignored. in_valid outside IDLE is ignored.
- Widths: all internal sums are sign-extended before addition. The accumulator wraps modulo 2^ACC_W; with the default ACC_W no overflow is possible.
- Reset mid-operation: abandon immediately, return to the reset values, no output produced.

Decomposition:
- Package mac_vert_pkg holds:
  - state enum mac_state_t.
  - derived localparam functions NUM_GROUPS, group-sum width and column-sum width.
- Sub-module mac_group_column: one group's slot muxes, P_g and skip-zero select. Instantiated NUM_GROUPS times.

Test Plan:
- Unsigned partial-select: act[i]=i-8, signed_w=0, one column with col_last=1, group0 sel={0,1,2,3}, group1 sel all 8, skip_zero={1,1} -> result=-26, out_valid 3 cycles after column accept.
- Signed all-ones weights: act all 3, signed_w=1, 8 columns, all sel=8, skip_zero=0, col_last on the 8th -> result=-48, col_overrun=0.
- Hamming term: act[5]=10, ham_en=1, ham_sel=5, ham_sign=1 at k=2; other contributions zero -> result=-40.
- Overrun: 8 columns without col_last -> 8th column is treated as last, col_overrun=1, col_ready=0 afterwards; the next in accept clears col_overrun.
- Backpressure: out_ready low for 5 cycles in DONE -> out_valid=1 and result stable, in_ready=0 and a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
- Async reset mid-RUN after 3 columns -> outputs immediately at reset values; after release a fresh operation yields a correct result.

Source files
------------

// File: rtl/mac_vert_pkg.sv
// Shared types and derived widths for the self-sequencing vertical bit-column MAC.
package mac_vert_pkg;

    typedef logic [2:0] mac_state_t;

    localparam mac_state_t StIdle  = 3'd0;
    localparam mac_state_t StLoad  = 3'd1;
    localparam mac_state_t StRun   = 3'd2;
    localparam mac_state_t StDrain = 3'd3;
    localparam mac_state_t StDone  = 3'd4;

    function automatic int num_groups(input int vec_length, input int group_size);
        return vec_length / group_size;
    endfunction

    function automatic int group_sum_w(input int data_width, input int group_size);
        return data_width + $clog2(group_size);
    endfunction

    // Room for S_g - P_g with repeated selects, the cross-group sum and MSB negation.
    function automatic int col_sum_w(input int data_width, input int group_size,
                                     input int n_groups);
        return group_sum_w(data_width, group_size) + $clog2(n_groups) + 2;
    endfunction

endpackage

// File: rtl/mac_group_column.sv
// One activation group: registered slot muxes (stage 1), then the slot sum and
// skip-zero select feeding the cross-group adder (stage 2).
module mac_group_column
    import mac_vert_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int GROUP_SIZE = 8,
    parameter int SLOTS      = GROUP_SIZE / 2,
    parameter int SEL_W      = $clog2(GROUP_SIZE + 1),
    localparam int GSW       = group_sum_w(DATA_WIDTH, GROUP_SIZE)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  load,
    input  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0] act,
    input  logic [SLOTS-1:0][SEL_W-1:0]           sel,
    input  logic                                  skip_zero,
    input  logic [GSW-1:0]                        group_sum,
    output logic [GSW:0]                          col_sum
);

    logic [SLOTS-1:0][DATA_WIDTH-1:0] slot_d, slot_q;
    logic                             skip_q;
    logic signed [GSW-1:0]            psum;

    // Out-of-range selects (>= GROUP_SIZE) match no input and leave the slot at zero.
    always_comb begin
        slot_d = '0;
        for (int s = 0; s < SLOTS; s++) begin
            for (int i = 0; i < GROUP_SIZE; i++) begin
                if (sel[s] == SEL_W'(i)) slot_d[s] = act[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q <= '0;
            skip_q <= 1'b0;
        end else if (load) begin
            slot_q <= slot_d;
            skip_q <= skip_zero;
        end
    end

    always_comb begin
        psum = '0;
        for (int s = 0; s < SLOTS; s++) begin
            psum = psum + GSW'($signed(slot_q[s]));
        end
        if (skip_q) col_sum = (GSW + 1)'(psum);
        else        col_sum = (GSW + 1)'($signed(group_sum)) - (GSW + 1)'(psum);
    end

endmodule

// File: rtl/mac_unit_vert_seq.sv
// Self-sequencing vertical bit-column MAC: latch activations, form group sums,
// then accumulate one shifted weight column per handshake into a signed result.
module mac_unit_vert_seq
    import mac_vert_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int VEC_LENGTH  = 16,
    parameter int GROUP_SIZE  = 8,
    parameter int SLOTS       = GROUP_SIZE / 2,
    parameter int WEIGHT_BITS = 8,
    parameter int SEL_W       = $clog2(GROUP_SIZE + 1),
    parameter int ACC_W       = DATA_WIDTH + $clog2(VEC_LENGTH) + WEIGHT_BITS + 2,
    localparam int NUM_GROUPS = num_groups(VEC_LENGTH, GROUP_SIZE),
    localparam int HSEL_W     = $clog2(VEC_LENGTH)
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]    act,
    input  logic                                     signed_w,
    input  logic                                     col_valid,
    output logic                                     col_ready,
    input  logic [NUM_GROUPS*SLOTS-1:0][SEL_W-1:0]   col_sel,
    input  logic [NUM_GROUPS-1:0]                    col_skip_zero,
    input  logic                                     col_last,
    input  logic                                     ham_en,
    input  logic [HSEL_W-1:0]                        ham_sel,
    input  logic                                     ham_sign,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [ACC_W-1:0]                         result,
    output logic                                     col_overrun
);

    localparam int GSW = group_sum_w(DATA_WIDTH, GROUP_SIZE);
    localparam int CSW = col_sum_w(DATA_WIDTH, GROUP_SIZE, NUM_GROUPS);
    localparam int KW  = $clog2(WEIGHT_BITS + 1);

    mac_state_t state_q, state_d;

    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q;
    logic                                  signed_w_q;
    logic [NUM_GROUPS-1:0][GSW-1:0]        gsum_d, gsum_q;
    logic [KW-1:0]                         k_q;
    logic                                  overrun_q;
    logic                                  drain_q;
    logic signed [ACC_W-1:0]               acc_q;

    logic                                  s1_valid_q;
    logic [KW-1:0]                         s1_k_q;
    logic                                  s1_msb_q;
    logic [DATA_WIDTH-1:0]                 ham_d, s1_ham_q;
    logic                                  s1_ham_sign_q;

    logic [NUM_GROUPS-1:0][GSW:0]          col_sum;
    logic signed [CSW-1:0]                 tsum;
    logic signed [ACC_W-1:0]               tsum_ext, ham_ext, term;

    logic in_fire, col_fire, k_at_max, col_is_last;

    assign in_fire     = (state_q == StIdle) && in_valid;
    assign col_fire    = (state_q == StRun) && col_valid;
    assign k_at_max    = (k_q == KW'(WEIGHT_BITS - 1));
    assign col_is_last = col_last || k_at_max;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (col_valid && col_is_last) state_d = StDrain;
            StDrain: if (drain_q) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gsum_d = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int i = 0; i < GROUP_SIZE; i++) begin
                gsum_d[g] = gsum_d[g] + GSW'($signed(act_q[g*GROUP_SIZE + i]));
            end
        end
    end

    always_comb begin
        ham_d = '0;
        if (ham_en) begin
            for (int i = 0; i < VEC_LENGTH; i++) begin
                if (ham_sel == HSEL_W'(i)) ham_d = act_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            act_q      <= '0;
            signed_w_q <= 1'b0;
            gsum_q     <= '0;
            k_q        <= '0;
            overrun_q  <= 1'b0;
            drain_q    <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                act_q      <= act;
                signed_w_q <= signed_w;
                k_q        <= '0;
                overrun_q  <= 1'b0;
                acc_q      <= '0;
            end else if (s1_valid_q) begin
                acc_q <= acc_q + term;
            end
            if (state_q == StLoad) gsum_q <= gsum_d;
            if (col_fire) begin
                k_q <= k_q + KW'(1);
                if (!col_last && k_at_max) overrun_q <= 1'b1;
            end
            if (state_q == StDrain) drain_q <= ~drain_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s1_k_q        <= '0;
            s1_msb_q      <= 1'b0;
            s1_ham_q      <= '0;
            s1_ham_sign_q <= 1'b0;
        end else begin
            s1_valid_q <= col_fire;
            if (col_fire) begin
                s1_k_q        <= k_q;
                s1_msb_q      <= col_last && signed_w_q;
                s1_ham_q      <= ham_d;
                s1_ham_sign_q <= ham_sign;
            end
        end
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        mac_group_column #(
            .DATA_WIDTH (DATA_WIDTH),
            .GROUP_SIZE (GROUP_SIZE),
            .SLOTS      (SLOTS),
            .SEL_W      (SEL_W)
        ) u_col (
            .clk       (clk),
            .reset     (reset),
            .load      (col_fire),
            .act       (act_q[g*GROUP_SIZE +: GROUP_SIZE]),
            .sel       (col_sel[g*SLOTS +: SLOTS]),
            .skip_zero (col_skip_zero[g]),
            .group_sum (gsum_q[g]),
            .col_sum   (col_sum[g])
        );
    end

    // The hamming term is shifted with the column but never takes the MSB negation.
    always_comb begin
        tsum = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            tsum = tsum + CSW'($signed(col_sum[g]));
        end
        if (s1_msb_q) tsum = -tsum;
        tsum_ext = ACC_W'(tsum);
        ham_ext  = ACC_W'($signed(s1_ham_q));
        if (s1_ham_sign_q) ham_ext = -ham_ext;
        term = (tsum_ext <<< s1_k_q) + (ham_ext <<< s1_k_q);
    end

    assign in_ready    = (state_q == StIdle);
    assign col_ready   = (state_q == StRun);
    assign out_valid   = (state_q == StDone);
    assign result      = acc_q;
    assign col_overrun = overrun_q;

endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// Directed bench for mac_unit_vert_seq with hand-computed dot products.
module tb_mac_unit_vert_seq;

    localparam int ACC_W = 22;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [15:0][7:0]  act;
    logic              signed_w;
    logic              col_valid;
    logic              col_ready;
    logic [7:0][3:0]   col_sel;
    logic [1:0]        col_skip_zero;
    logic              col_last;
    logic              ham_en;
    logic [3:0]        ham_sel;
    logic              ham_sign;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  result;
    logic              col_overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0][3:0] sel_none;

    mac_unit_vert_seq dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .act           (act),
        .signed_w      (signed_w),
        .col_valid     (col_valid),
        .col_ready     (col_ready),
        .col_sel       (col_sel),
        .col_skip_zero (col_skip_zero),
        .col_last      (col_last),
        .ham_en        (ham_en),
        .ham_sel       (ham_sel),
        .ham_sign      (ham_sign),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .col_overrun   (col_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0][7:0] a, input logic sw);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin step(); n++; end
        act = a;
        signed_w = sw;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (col_ready !== 1'b1 && n < 10) begin step(); n++; end
        checks++;
        if (col_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_op: col_ready=%b, required 1 within 10 cycles", col_ready);
        end
    endtask

    task automatic send_col(input logic [7:0][3:0] sel, input logic [1:0] skip, input logic last,
                            input logic hen, input logic [3:0] hsel, input logic hsign);
        col_valid = 1'b1;
        col_sel = sel;
        col_skip_zero = skip;
        col_last = last;
        ham_en = hen;
        ham_sel = hsel;
        ham_sign = hsign;
        step();
        col_valid = 1'b0;
        col_last = 1'b0;
        ham_en = 1'b0;
        ham_sign = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: out_valid=%b, required 1 within 40 cycles", out_valid);
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks += 5;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        if (col_ready !== 1'b0) begin errors++; $display("FAIL reset_col_ready: got %b, required 0", col_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d, required 0", result); end
        if (col_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", col_overrun); end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_partial_select();
        logic [15:0][7:0] a;
        logic [7:0][3:0] s;
        logic signed [ACC_W-1:0] exp_r;
        int n;
        for (int i = 0; i < 16; i++) a[i] = 8'(i - 8);
        for (int j = 0; j < 4; j++) s[j] = 4'(j);
        for (int j = 4; j < 8; j++) s[j] = 4'd8;
        start_op(a, 1'b0);
        send_col(s, 2'b11, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_done(n);
        exp_r = -26;
        checks += 2;
        if (n != 2) begin errors++; $display("FAIL partial_latency: out_valid after %0d extra cycles, required 2", n); end
        if (result !== exp_r) begin
            errors++; $display("FAIL partial_result: got %0d, required %0d", $signed(result), exp_r);
        end
        pop();
    endtask

    task automatic test_signed_weights();
        logic [15:0][7:0] a;
        logic signed [ACC_W-1:0] exp_r;
        int n;
        for (int i = 0; i < 16; i++) a[i] = 8'd3;
        start_op(a, 1'b1);
        for (int c = 0; c < 8; c++) send_col(sel_none, 2'b00, c == 7, 1'b0, 4'd0, 1'b0);
        wait_done(n);
        exp_r = -48;
        checks += 2;
        if (result !== exp_r) begin
            errors++; $display("FAIL signed_result: got %0d, required %0d", $signed(result), exp_r);
        end
        if (col_overrun !== 1'b0) begin errors++; $display("FAIL signed_overrun: got %b, required 0", col_overrun); end
        pop();
    endtask

    task automatic test_hamming();
        logic [15:0][7:0] a;
        logic signed [ACC_W-1:0] exp_r;
        int n;
        a = '0;
        a[5] = 8'd10;
        start_op(a, 1'b0);
        send_col(sel_none, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        send_col(sel_none, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        send_col(sel_none, 2'b11, 1'b1, 1'b1, 4'd5, 1'b1);
        wait_done(n);
        exp_r = -40;
        checks++;
        if (result !== exp_r) begin
            errors++; $display("FAIL hamming_result: got %0d, required %0d", $signed(result), exp_r);
        end
        pop();
    endtask

    task automatic test_overrun();
        logic [15:0][7:0] a;
        logic signed [ACC_W-1:0] exp_r;
        int n;
        for (int i = 0; i < 16; i++) a[i] = 8'd1;
        start_op(a, 1'b1);
        for (int c = 0; c < 8; c++) send_col(sel_none, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        checks += 2;
        if (col_ready !== 1'b0) begin errors++; $display("FAIL overrun_col_ready: got %b, required 0", col_ready); end
        if (col_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b, required 1", col_overrun); end
        wait_done(n);
        exp_r = 4080;
        checks++;
        if (result !== exp_r) begin
            errors++; $display("FAIL overrun_result: got %0d, required %0d", $signed(result), exp_r);
        end
        pop();
        checks++;
        if (col_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b, required 1", col_overrun); end
    endtask

    task automatic test_backpressure();
        logic [15:0][7:0] a;
        logic [7:0][3:0] s;
        logic signed [ACC_W-1:0] exp_r;
        int n;
        for (int i = 0; i < 16; i++) a[i] = 8'(i);
        start_op(a, 1'b0);
        checks++;
        if (col_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b, required 0", col_overrun); end
        s[0] = 4'd7; s[1] = 4'd7; s[2] = 4'd0; s[3] = 4'd8;
        s[4] = 4'd0; s[5] = 4'd1; s[6] = 4'd2; s[7] = 4'd3;
        send_col(s, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0);
        send_col(sel_none, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_done(n);
        exp_r = 292;
        for (int i = 0; i < 16; i++) act[i] = 8'h7f;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b, required 1", c, out_valid); end
            if (result !== exp_r) begin
                errors++; $display("FAIL bp_result[%0d]: got %0d, required %0d", c, $signed(result), exp_r);
            end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", c, in_ready); end
        end
        in_valid = 1'b0;
        pop();
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b, required 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b, required 1", in_ready); end
        if (col_ready !== 1'b0) begin errors++; $display("FAIL bp_release_col_ready: got %b, required 0", col_ready); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0][7:0] a;
        logic signed [ACC_W-1:0] exp_r;
        int n;
        for (int i = 0; i < 16; i++) a[i] = 8'd2;
        start_op(a, 1'b0);
        for (int c = 0; c < 3; c++) send_col(sel_none, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks += 5;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
        if (col_ready !== 1'b0) begin errors++; $display("FAIL midrst_col_ready: got %b, required 0", col_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
        if (result !== '0) begin errors++; $display("FAIL midrst_result: got %0d, required 0", $signed(result)); end
        if (col_overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b, required 0", col_overrun); end
        @(negedge clk);
        reset = 1'b1;
        step();
        start_op(a, 1'b1);
        send_col(sel_none, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        send_col(sel_none, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_done(n);
        exp_r = -32;
        checks++;
        if (result !== exp_r) begin
            errors++; $display("FAIL midrst_fresh_result: got %0d, required %0d", $signed(result), exp_r);
        end
        pop();
    endtask

    initial begin
        in_valid = 1'b0;
        act = '0;
        signed_w = 1'b0;
        col_valid = 1'b0;
        col_sel = '0;
        col_skip_zero = '0;
        col_last = 1'b0;
        ham_en = 1'b0;
        ham_sel = '0;
        ham_sign = 1'b0;
        out_ready = 1'b0;
        for (int j = 0; j < 8; j++) sel_none[j] = 4'd8;

        test_reset();
        test_partial_select();
        test_signed_weights();
        test_hamming();
        test_overrun();
        test_backpressure();
        test_reset_mid_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
